// File: rtl/instr_encoder_pkg.sv
// ============================================================================
//  Module      : instr_encoder_pkg
//  Description : Shared processor encoding package: operation enum, opcode and
//                func field values, encoder FSM states and word-pack helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package instr_encoder_pkg;

    typedef enum logic [4:0] {
        OP_ADD  = 5'd0,
        OP_SUB  = 5'd1,
        OP_AND  = 5'd2,
        OP_OR   = 5'd3,
        OP_SLT  = 5'd4,
        OP_SLL  = 5'd5,
        OP_SRL  = 5'd6,
        OP_ROTR = 5'd7,
        OP_CLO  = 5'd8,
        OP_CLZ  = 5'd9,
        OP_MUL  = 5'd10,
        OP_ADDI = 5'd11,
        OP_ORI  = 5'd12,
        OP_SW   = 5'd13,
        OP_LW   = 5'd14,
        OP_BNE  = 5'd15
    } op_e;

    // Major opcodes
    localparam logic [5:0] c_OPC_SPECIAL  = 6'b000000;
    localparam logic [5:0] c_OPC_SPECIAL2 = 6'b011100;
    localparam logic [5:0] c_OPC_ADDI     = 6'b001000;
    localparam logic [5:0] c_OPC_ORI      = 6'b001101;
    localparam logic [5:0] c_OPC_SW       = 6'b101011;
    localparam logic [5:0] c_OPC_LW       = 6'b100011;
    localparam logic [5:0] c_OPC_BNE      = 6'b000101;

    // SPECIAL func codes
    localparam logic [5:0] c_FN_ADD  = 6'b100000;
    localparam logic [5:0] c_FN_SUB  = 6'b100010;
    localparam logic [5:0] c_FN_AND  = 6'b100100;
    localparam logic [5:0] c_FN_OR   = 6'b100101;
    localparam logic [5:0] c_FN_SLT  = 6'b101010;
    localparam logic [5:0] c_FN_SLL  = 6'b000000;
    localparam logic [5:0] c_FN_SRL  = 6'b000010;
    localparam logic [5:0] c_FN_ROTR = 6'b000110;

    // SPECIAL2 func codes
    localparam logic [5:0] c_FN2_CLO = 6'b100001;
    localparam logic [5:0] c_FN2_CLZ = 6'b100000;
    localparam logic [5:0] c_FN2_MUL = 6'b000010;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_FULL  = 2'd2
    } enc_state_e;

    function automatic logic [31:0] pack_r(
        input logic [5:0] opc,
        input logic [4:0] rs,
        input logic [4:0] rt,
        input logic [4:0] rd,
        input logic [4:0] shamt,
        input logic [5:0] fn
    );
        return {opc, rs, rt, rd, shamt, fn};
    endfunction

    function automatic logic [31:0] pack_i(
        input logic [5:0]  opc,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [15:0] imm
    );
        return {opc, rs, rt, imm};
    endfunction

endpackage

`default_nettype wire

// File: rtl/instr_encoder_if.sv
// ============================================================================
//  Module      : instr_encoder_if
//  Description : Descriptor input, base control, status and instruction-memory
//                write port of the instruction encoder.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface instr_encoder_if #(
    parameter int AW = 8
);
    logic          in_valid;
    logic          in_ready;
    logic [4:0]    in_op;
    logic [4:0]    in_rs;
    logic [4:0]    in_rt;
    logic [4:0]    in_rd;
    logic [4:0]    in_shamt;
    logic [15:0]   in_imm;

    logic          base_we;
    logic [AW-1:0] base_addr;

    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          imem_ack;

    logic [AW:0]   word_count;
    logic          err_illegal;

    // Loader plus memory side
    modport master (
        output in_valid, in_op, in_rs, in_rt, in_rd, in_shamt, in_imm,
        output base_we, base_addr,
        output imem_ack,
        input  in_ready, imem_we, imem_addr, imem_wdata, word_count, err_illegal
    );

    // Encoder side
    modport slave (
        input  in_valid, in_op, in_rs, in_rt, in_rd, in_shamt, in_imm,
        input  base_we, base_addr,
        input  imem_ack,
        output in_ready, imem_we, imem_addr, imem_wdata, word_count, err_illegal
    );

endinterface

`default_nettype wire

// File: rtl/instr_field_pack.sv
// ============================================================================
//  Module      : instr_field_pack
//  Description : Combinational op + fields to 32-bit instruction word, with a
//                flag for operation codes outside the defined set.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_field_pack
    import instr_encoder_pkg::*;
(
    input  logic [4:0]  i_op,
    input  logic [4:0]  i_rs,
    input  logic [4:0]  i_rt,
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_shamt,
    input  logic [15:0] i_imm,
    output logic [31:0] o_word,
    output logic        o_illegal
);

    always_comb begin
        o_word    = '0;
        o_illegal = 1'b0;
        case (i_op)
            OP_ADD:  o_word = pack_r(c_OPC_SPECIAL, i_rs, i_rt, i_rd, 5'd0, c_FN_ADD);
            OP_SUB:  o_word = pack_r(c_OPC_SPECIAL, i_rs, i_rt, i_rd, 5'd0, c_FN_SUB);
            OP_AND:  o_word = pack_r(c_OPC_SPECIAL, i_rs, i_rt, i_rd, 5'd0, c_FN_AND);
            OP_OR:   o_word = pack_r(c_OPC_SPECIAL, i_rs, i_rt, i_rd, 5'd0, c_FN_OR);
            OP_SLT:  o_word = pack_r(c_OPC_SPECIAL, i_rs, i_rt, i_rd, 5'd0, c_FN_SLT);
            // Immediate shifts carry the amount in shamt and leave rs zero
            OP_SLL:  o_word = pack_r(c_OPC_SPECIAL, 5'd0, i_rt, i_rd, i_shamt, c_FN_SLL);
            OP_SRL:  o_word = pack_r(c_OPC_SPECIAL, 5'd0, i_rt, i_rd, i_shamt, c_FN_SRL);
            OP_ROTR: o_word = pack_r(c_OPC_SPECIAL, i_rs, i_rt, i_rd, 5'd0, c_FN_ROTR);
            // Count-leading ops name the destination in both rt and rd
            OP_CLO:  o_word = pack_r(c_OPC_SPECIAL2, i_rs, i_rd, i_rd, 5'd0, c_FN2_CLO);
            OP_CLZ:  o_word = pack_r(c_OPC_SPECIAL2, i_rs, i_rd, i_rd, 5'd0, c_FN2_CLZ);
            OP_MUL:  o_word = pack_r(c_OPC_SPECIAL2, i_rs, i_rt, i_rd, 5'd0, c_FN2_MUL);
            OP_ADDI: o_word = pack_i(c_OPC_ADDI, i_rs, i_rt, i_imm);
            OP_ORI:  o_word = pack_i(c_OPC_ORI,  i_rs, i_rt, i_imm);
            OP_SW:   o_word = pack_i(c_OPC_SW,   i_rs, i_rt, i_imm);
            OP_LW:   o_word = pack_i(c_OPC_LW,   i_rs, i_rt, i_imm);
            OP_BNE:  o_word = pack_i(c_OPC_BNE,  i_rs, i_rt, i_imm);
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/instr_encoder.sv
// ============================================================================
//  Module      : instr_encoder
//  Description : Encodes operation descriptors and writes them sequentially to
//                instruction memory. Optional macro ENC_ILLEGAL_TRAP_EN traps
//                illegal ops (not written, sticky err_illegal).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int AW = 8
)(
    input  logic          clk,
    input  logic          rst,
    instr_encoder_if.slave bus
);

    localparam logic [AW:0] c_CAPACITY = {1'b1, {AW{1'b0}}};

    enc_state_e    r_state;
    logic [AW-1:0] r_ptr;
    logic [AW-1:0] r_addr;
    logic [31:0]   r_wdata;
    logic          r_we;
    logic [AW:0]   r_count;

    logic [31:0]   w_word;
    logic          w_illegal;
    logic          w_in_ready;
    logic          w_accept;
    logic          w_trap;
    logic          w_start;
    logic [AW:0]   w_count_inc;

    instr_field_pack u_pack (
        .i_op      (bus.in_op),
        .i_rs      (bus.in_rs),
        .i_rt      (bus.in_rt),
        .i_rd      (bus.in_rd),
        .i_shamt   (bus.in_shamt),
        .i_imm     (bus.in_imm),
        .o_word    (w_word),
        .o_illegal (w_illegal)
    );

    assign w_in_ready  = (r_state == S_IDLE) && !rst;
    // base_we on the same edge claims the cycle, so the descriptor is refused
    assign w_accept    = bus.in_valid && w_in_ready && !bus.base_we;
    assign w_start     = w_accept && !w_trap;
    assign w_count_inc = r_count + 1'b1;

`ifdef ENC_ILLEGAL_TRAP_EN
    logic r_err;

    assign w_trap          = w_illegal;
    assign bus.err_illegal = r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (bus.base_we && (r_state != S_WRITE)) begin
            r_err <= 1'b0;
        end else if (w_accept && w_illegal) begin
            r_err <= 1'b1;
        end
    end
`else
    logic w_unused_illegal;

    // Illegal ops already pack to the all-zero nop and are written as such
    assign w_trap           = 1'b0;
    assign w_unused_illegal = w_illegal;
    assign bus.err_illegal  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_we    <= 1'b0;
            r_count <= '0;
        end else if (bus.base_we && (r_state != S_WRITE)) begin
            r_state <= S_IDLE;
            r_ptr   <= bus.base_addr;
            r_count <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_addr  <= r_ptr;
                        r_wdata <= w_word;
                        r_we    <= 1'b1;
                        r_state <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (bus.imem_ack) begin
                        r_we    <= 1'b0;
                        r_ptr   <= r_ptr + 1'b1;
                        r_count <= w_count_inc;
                        r_state <= (w_count_inc == c_CAPACITY) ? S_FULL : S_IDLE;
                    end
                end
                S_FULL: begin
                    r_state <= S_FULL;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_we    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.imem_we    = r_we;
    assign bus.imem_addr  = r_addr;
    assign bus.imem_wdata = r_wdata;
    assign bus.word_count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_instr_encoder.sv
// ============================================================================
//  Module      : tb_instr_encoder
//  Description : Scoreboard bench for instr_encoder with a small address space
//                so pointer wrap and the full condition occur often.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_encoder;

    localparam int AW  = 2;
    localparam int CAP = 1 << AW;
`ifdef ENC_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    instr_encoder_if #(.AW(AW)) bus ();

    instr_encoder #(.AW(AW)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t          sb_q[$];
    int            total      = 0;
    int            bad        = 0;
    int            acked      = 0;
    int            count_base = 0;
    int            issued     = 0;
    int            ack_fixed  = -1;
    logic [AW-1:0] exp_ptr    = '0;
    bit            exp_err    = 1'b0;
    bit            ack_hold   = 1'b0;
    bit            spurious   = 1'b0;

    task automatic check(input string name, input longint act, input longint req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Reference encoding from the opcode/func tables; returns {written, word}
    function automatic logic [32:0] ref_encode(input int op, input int rs, input int rt,
                                               input int rd, input int sh, input int imm);
        longint opc = 0;
        longint fn  = 0;
        longint frs = rs;
        longint frt = rt;
        longint fsh = 0;
        longint w;
        bit     itype = 1'b0;
        case (op)
            0:  fn = 32;
            1:  fn = 34;
            2:  fn = 36;
            3:  fn = 37;
            4:  fn = 42;
            5:  begin fn = 0; frs = 0; fsh = sh; end
            6:  begin fn = 2; frs = 0; fsh = sh; end
            7:  fn = 6;
            8:  begin opc = 28; fn = 33; frt = rd; end
            9:  begin opc = 28; fn = 32; frt = rd; end
            10: begin opc = 28; fn = 2; end
            11: begin opc = 8;  itype = 1'b1; end
            12: begin opc = 13; itype = 1'b1; end
            13: begin opc = 43; itype = 1'b1; end
            14: begin opc = 35; itype = 1'b1; end
            15: begin opc = 5;  itype = 1'b1; end
            default: return {!TRAP, 32'h0};
        endcase
        if (itype)
            w = opc * (2**26) + frs * (2**21) + frt * (2**16) + imm;
        else
            w = opc * (2**26) + frs * (2**21) + frt * (2**16) + rd * (2**11) + fsh * 64 + fn;
        return {1'b1, w[31:0]};
    endfunction

    // Memory model and monitor: checks every write cycle against the queue head
    initial begin
        int wc  = 0;
        int dly = 0;
        bus.imem_ack = 1'b0;
        forever begin
            @(negedge clk);
            check("word_count", bus.word_count, acked - count_base);
            check("err_illegal", bus.err_illegal, exp_err);
            bus.imem_ack = 1'b0;
            if (bus.imem_we) begin
                check("busy_in_ready", bus.in_ready, 0);
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write: actual addr=0x%0h data=0x%0h required=no write",
                             bus.imem_addr, bus.imem_wdata);
                end else begin
                    check("imem_addr", bus.imem_addr, sb_q[0].addr);
                    check("imem_wdata", bus.imem_wdata, sb_q[0].data);
                end
                if (wc == 0) dly = (ack_fixed >= 0) ? ack_fixed : int'($urandom_range(0, 3));
                if (!ack_hold && wc >= dly) begin
                    bus.imem_ack = 1'b1;
                    wc = 0;
                    if (sb_q.size() != 0) void'(sb_q.pop_front());
                    acked++;
                end else begin
                    wc++;
                end
            end else begin
                wc = 0;
                if (spurious && $urandom_range(0, 3) == 0) bus.imem_ack = 1'b1;
            end
        end
    end

    // All stimulus tasks start and end at 2 time units after a rising edge
    task automatic send(input logic [4:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm,
                        input logic [31:0] word, input bit wr);
        bit acc = 1'b0;
        bit rdy;
        bus.in_op = op; bus.in_rs = rs; bus.in_rt = rt; bus.in_rd = rd;
        bus.in_shamt = sh; bus.in_imm = imm; bus.in_valid = 1'b1;
        for (int i = 0; i < 60 && !acc; i++) begin
            @(negedge clk);
            rdy = bus.in_ready;
            @(posedge clk);
            if (rdy) begin
                acc = 1'b1;
                if (wr) begin
                    sb_q.push_back('{addr: exp_ptr, data: word});
                    exp_ptr = exp_ptr + 1'b1;
                    issued++;
                end
            end
        end
        #2;
        bus.in_valid = 1'b0;
        check("accepted", acc, 1);
        if (acc && !wr) exp_err = 1'b1;
    endtask

    task automatic send_rand(input int op);
        logic [4:0]  rs, rt, rd, sh;
        logic [15:0] imm;
        logic [32:0] r;
        rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom);
        sh = 5'($urandom); imm = 16'($urandom);
        r = ref_encode(op, int'(rs), int'(rt), int'(rd), int'(sh), int'(imm));
        send(5'(op), rs, rt, rd, sh, imm, r[31:0], r[32]);
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(posedge clk); #2;
            n++;
        end
        check("drain_pending", sb_q.size(), 0);
    endtask

    task automatic do_base(input logic [AW-1:0] a);
        bus.base_we = 1'b1;
        bus.base_addr = a;
        @(posedge clk); #2;
        bus.base_we = 1'b0;
        exp_ptr = a; count_base = acked; issued = 0; exp_err = 1'b0;
    endtask

    task automatic expect_full();
        drain();
        @(posedge clk); #2;
        check("full_in_ready", bus.in_ready, 0);
        check("full_count", bus.word_count, CAP);
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.in_op = '0; bus.in_rs = '0; bus.in_rt = '0;
        bus.in_rd = '0; bus.in_shamt = '0; bus.in_imm = '0;
        bus.base_we = 1'b0; bus.base_addr = '0;

        repeat (3) begin
            @(negedge clk);
            check("rst_in_ready", bus.in_ready, 0);
            check("rst_imem_we", bus.imem_we, 0);
            check("rst_imem_addr", bus.imem_addr, 0);
            check("rst_imem_wdata", bus.imem_wdata, 0);
        end
        @(posedge clk); #2;
        rst = 1'b0;
        @(negedge clk);
        check("idle_in_ready", bus.in_ready, 1);
        @(posedge clk); #2;

        // Directed encodings, filling all four words from address 0
        send(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 32'h0022_1820, 1'b1);
        drain();
        check("count_after_add", bus.word_count, 1);
        send(5'd11, 5'd0, 5'd8, 5'd0, 5'd0, 16'h0005, 32'h2008_0005, 1'b1);
        send(5'd14, 5'd29, 5'd9, 5'd0, 5'd0, 16'h0004, 32'h8FA9_0004, 1'b1);
        send(5'd15, 5'd1, 5'd2, 5'd0, 5'd0, 16'hFFFE, 32'h1422_FFFE, 1'b1);
        expect_full();
        do_base('0);

        // Long ack stall, then MUL
        ack_fixed = 5;
        send(5'd5, 5'd7, 5'd1, 5'd2, 5'd4, 16'h0, 32'h0001_1100, 1'b1);
        ack_fixed = -1;
        send(5'd10, 5'd5, 5'd6, 5'd4, 5'd0, 16'h0, 32'h70A6_2002, 1'b1);
        drain();

        // Wrap from base 3: addresses 3,0,1,2 then full
        do_base(2'd3);
        for (int i = 0; i < CAP; i++) send_rand(int'($urandom_range(0, 15)));
        expect_full();
        do_base(2'd1);
        check("base_release_ready", bus.in_ready, 1);
        check("base_release_count", bus.word_count, 0);

        // base_we and a handshake on the same edge: base wins
        bus.in_op = 5'd0; bus.in_valid = 1'b1;
        bus.base_we = 1'b1; bus.base_addr = 2'd2;
        @(posedge clk); #2;
        bus.in_valid = 1'b0; bus.base_we = 1'b0;
        exp_ptr = 2'd2; count_base = acked; issued = 0; exp_err = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("base_win_ready", bus.in_ready, 1);
        send_rand(0);
        drain();

        // Illegal operation code
        send_rand(20);
        check("illegal_in_ready", bus.in_ready, TRAP ? 1 : 0);
        drain();
        repeat (2) @(posedge clk);
        #2;
        do_base('0);

        // Randomised traffic with random ack latency and stray acks
        spurious = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (issued == CAP) begin
                expect_full();
                do_base(AW'($urandom));
            end
            send_rand(int'($urandom_range(0, 19)));
        end
        drain();
        spurious = 1'b0;
        @(posedge clk); #2;
        do_base('0);

        // Reset in the middle of a write abandons it
        ack_hold = 1'b1;
        send_rand(3);
        @(posedge clk); #2;
        rst = 1'b1;
        check("rst_in_ready_mid", bus.in_ready, 0);
        @(posedge clk); #1;
        check("rst_abandon_we", bus.imem_we, 0);
        #1;
        rst = 1'b0;
        sb_q.delete();
        count_base = acked; exp_ptr = '0; issued = 0; exp_err = 1'b0;
        ack_hold = 1'b0;
        send_rand(1);
        drain();
        @(posedge clk); #2;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/instr_encoder.md
# instr_encoder

Streams operation descriptors in, packs each into a 32-bit instruction word using the processor's opcode/func encoding, and writes the words sequentially into instruction memory. It is the encode side of the control decoder: every word it emits decodes to the intended control vector. It sits between the test/boot loader and the instruction-memory write port, with valid/ready on the input and a request/ack write port on the output.

## Interface
- AW, 8, instruction-memory word-address width; capacity 2^AW words
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  descriptor valid
- in_ready  out  1  encoder can accept; combinational from state
- in_op  in  5  operation: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 SLL, 6 SRL, 7 ROTR, 8 CLO, 9 CLZ, 10 MUL, 11 ADDI, 12 ORI, 13 SW, 14 LW, 15 BNE, 16–31 illegal
- in_rs, in_rt, in_rd, in_shamt  in  5 each  register and shift fields
- in_imm  in  16  immediate / branch offset
- base_we  in  1  load write pointer, clear count and error
- base_addr  in  AW  new write pointer
- imem_we  out  1  write request
- imem_addr  out  AW  write word address
- imem_wdata  out  32  encoded instruction
- imem_ack  in  1  memory accepted the write this cycle
- word_count  out  AW+1  words written since reset/base_we
- err_illegal  out  1  sticky illegal-op flag

## Operation
- Layout: opcode[31:26] rs[25:21] rt[20:16] rd[15:11] shamt[10:6] func[5:0]; I-type imm[15:0].
- R-type (opcode 000000), func: ADD 100000, SUB 100010, AND 100100, OR 100101, SLT 101010, SLL 000000, SRL 000010, ROTR 000110. SLL/SRL force rs=0; other R-type ops force shamt=0.
- SPECIAL2 (opcode 011100), func: CLO 100001, CLZ 100000, MUL 000010. CLO/CLZ put in_rd in both rt and rd; shamt=0.
- I-type: ADDI 001000, ORI 001101, SW 101011, LW 100011, BNE 000101. Fields: rs, rt, imm; rd/shamt inputs ignored.
- FSM states:
  - IDLE: in_ready=1. On handshake, register the word and the current address, go to WRITE.
  - WRITE: imem_we=1; hold addr/data stable until imem_ack. On ack: pointer+1 mod 2^AW, word_count+1, go to FULL if count reaches 2^AW, else IDLE.
  - FULL: in_ready=0. base_we → IDLE.
- base_we applies in IDLE/FULL; ignored in WRITE. On the same edge as a handshake in IDLE, base_we wins and the descriptor is not accepted.
- Pointer wraps 2^AW-1 → 0. word_count saturates via FULL.

## Timing
- Reset values: imem_we 0, imem_addr 0, imem_wdata 0, word_count 0, err_illegal 0, state IDLE. in_ready is 0 while rst is high.
- Handshake at edge N → imem_we=1 in cycle N+1. Ack in cycle N+1 → in_ready=1 in cycle N+2. Peak throughput is one word per 2 cycles.
- Ack when imem_we=0 is ignored.
- rst during WRITE abandons the write; imem_we=0 from the next cycle.

## Configuration
- ENC_ILLEGAL_TRAP_EN defined: an illegal in_op is accepted but not written. err_illegal is set and held until rst or base_we; the pointer does not advance and the FSM stays in IDLE.
- Undefined: an illegal in_op encodes as 0x00000000 (sll $0,$0,0) and is written normally; err_illegal is tied to 0.

## Structure
- The op enum and the opcode/func localparams go in the shared processor package, so the decoder and the encoder use one source.
- Sub-module instr_field_pack: purely combinational op+fields → 32-bit word plus an illegal flag. The FSM, pointer and counter live in the top.

## Test plan
- ADD rd=3 rs=1 rt=2 → imem_wdata 0x00221820 at imem_addr 0; word_count=1 after ack.
- ADDI rt=8 rs=0 imm=5 → 0x20080005. LW rt=9 rs=29 imm=4 → 0x8FA90004. BNE rs=1 rt=2 imm=0xFFFE → 0x1422FFFE.
- SLL rd=2 rt=1 shamt=4 with rs=7 → 0x00011100 (rs forced 0). MUL rd=4 rs=5 rt=6 → 0x70A62002.
- Ack held low 5 cycles → addr/data stable, in_ready=0 throughout; completes on the ack cycle.
- AW=2, base_addr=3: write 4 words → addresses 3,0,1,2; FULL with in_ready=0; base_we → IDLE, count=0.
- in_op=20: with ENC_ILLEGAL_TRAP_EN → no imem_we, err_illegal=1 until base_we. Without it → 0x00000000 written.
